// File: rtl/aemb2_bus_pkg.sv
// Shared definitions for the aemb2 data-side bus bridge.
// State encoding, default geometry and timeout-counter sizing.
package aemb2_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCL = 2'd1,
        ST_EXTN = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int DEF_LAW   = 14;
    localparam int DEF_LBASE = 0;
    localparam int DEF_TMO   = 255;

    function automatic int tmo_w(input int tmo);
        return $clog2(tmo + 1);
    endfunction

    localparam int TMO_W = tmo_w(DEF_TMO);

endpackage

// File: rtl/aemb2_wb_tmo.sv
// External-bus timeout counter.
// Counts enabled cycles; expired_o is high while the count sits at TMO.
module aemb2_wb_tmo
    import aemb2_bus_pkg::*;
#(
    parameter int TMO = DEF_TMO
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = tmo_w(TMO);
    localparam logic [W-1:0] LIMIT = W'(TMO);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step up and saturate at TMO.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/aemb2_dwb_bridge.sv
// CPU data-bus router: local RAM window on mwb, everything else on xwb.
// One transfer in flight; each ends in one registered ack or error.
module aemb2_dwb_bridge
    import aemb2_bus_pkg::*;
#(
    parameter int AW    = 32,
    parameter int LAW   = DEF_LAW,
    parameter int LBASE = DEF_LBASE,
    parameter int TMO   = DEF_TMO
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    input  logic [AW-1:0]   dwb_adr_o,
    input  logic [31:0]     dwb_dat_o,
    input  logic [3:0]      dwb_sel_o,
    input  logic            dwb_wre_o,
    input  logic            dwb_stb_o,
    input  logic            dwb_cyc_o,
    output logic [31:0]     dwb_dat_i,
    output logic            dwb_ack_i,
    output logic            dwb_err_i,
    output logic [LAW-3:0]  mwb_adr_o,
    output logic [31:0]     mwb_dat_o,
    output logic [3:0]      mwb_sel_o,
    output logic            mwb_wre_o,
    output logic            mwb_stb_o,
    output logic            mwb_cyc_o,
    input  logic [31:0]     mwb_dat_i,
    input  logic            mwb_ack_i,
    output logic [AW-1:0]   xwb_adr_o,
    output logic [31:0]     xwb_dat_o,
    output logic [3:0]      xwb_sel_o,
    output logic            xwb_wre_o,
    output logic            xwb_stb_o,
    output logic            xwb_cyc_o,
    input  logic [31:0]     xwb_dat_i,
    input  logic            xwb_ack_i,
    input  logic            xwb_err_i
);

    localparam logic [AW-1:0] LBASE_W = AW'(LBASE);

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          wre_q, wre_d;
    logic          mstb_q, mstb_d;
    logic          xstb_q, xstb_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          in_extn;
    logic          tmo_exp;
    logic          is_local;

    assign in_extn  = (state_q == ST_EXTN);
    assign is_local = (dwb_adr_o[AW-1:LAW] == LBASE_W[AW-LAW-1:0]);

    aemb2_wb_tmo #(
        .TMO (TMO)
    ) u_tmo (
        .clk_i     (sys_clk_i),
        .rst_i     (sys_rst_i),
        .clr_i     (!in_extn),
        .en_i      (in_extn),
        .expired_o (tmo_exp)
    );

    // Next-state and registered-output decode; completions default low.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        wre_d   = wre_q;
        mstb_d  = mstb_q;
        xstb_d  = xstb_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dwb_stb_o && dwb_cyc_o) begin
                    adr_d = dwb_adr_o;
                    dat_d = dwb_dat_o;
                    sel_d = dwb_sel_o;
                    wre_d = dwb_wre_o;
                    if (is_local) begin
                        state_d = ST_LOCL;
                        mstb_d  = 1'b1;
                    end else begin
                        state_d = ST_EXTN;
                        xstb_d  = 1'b1;
                    end
                end
            end
            ST_LOCL: begin
                if (mwb_ack_i) begin
                    mstb_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                    if (!wre_q) begin
                        rdat_d = mwb_dat_i;
                    end
                end
            end
            ST_EXTN: begin
                if (xwb_err_i) begin
                    xstb_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (xwb_ack_i) begin
                    xstb_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                    if (!wre_q) begin
                        rdat_d = xwb_dat_i;
                    end
                end else if (tmo_exp) begin
                    xstb_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            wre_q   <= 1'b0;
            mstb_q  <= 1'b0;
            xstb_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            wre_q   <= wre_d;
            mstb_q  <= mstb_d;
            xstb_q  <= xstb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    assign dwb_dat_i = rdat_q;
    assign dwb_ack_i = ack_q;
    assign dwb_err_i = err_q;

    assign mwb_adr_o = adr_q[LAW-1:2];
    assign mwb_dat_o = dat_q;
    assign mwb_sel_o = sel_q;
    assign mwb_wre_o = wre_q;
    assign mwb_stb_o = mstb_q;
    assign mwb_cyc_o = mstb_q;

    assign xwb_adr_o = adr_q;
    assign xwb_dat_o = dat_q;
    assign xwb_sel_o = sel_q;
    assign xwb_wre_o = wre_q;
    assign xwb_stb_o = xstb_q;
    assign xwb_cyc_o = xstb_q;

endmodule

// File: tb/tb_aemb2_dwb_bridge.sv
// Self-checking bench for aemb2_dwb_bridge.
// Directed and random transfers against a memory/latency reference model.
module tb_aemb2_dwb_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        sys_rst_i;
    logic [31:0] dwb_adr_o, dwb_dat_o;
    logic [3:0]  dwb_sel_o;
    logic        dwb_wre_o, dwb_stb_o, dwb_cyc_o;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i, dwb_err_i;
    logic [11:0] mwb_adr_o;
    logic [31:0] mwb_dat_o;
    logic [3:0]  mwb_sel_o;
    logic        mwb_wre_o, mwb_stb_o, mwb_cyc_o;
    logic [31:0] mwb_dat_i;
    logic        mwb_ack_i;
    logic [31:0] xwb_adr_o, xwb_dat_o;
    logic [3:0]  xwb_sel_o;
    logic        xwb_wre_o, xwb_stb_o, xwb_cyc_o;
    logic [31:0] xwb_dat_i;
    logic        xwb_ack_i, xwb_err_i;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_mem [4096];
    logic [31:0] ram [4096];
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    aemb2_dwb_bridge #(.AW(32), .LAW(14), .LBASE(0), .TMO(TMO)) dut (
        .sys_clk_i(clk), .sys_rst_i(sys_rst_i),
        .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o),
        .dwb_sel_o(dwb_sel_o), .dwb_wre_o(dwb_wre_o),
        .dwb_stb_o(dwb_stb_o), .dwb_cyc_o(dwb_cyc_o),
        .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
        .dwb_err_i(dwb_err_i),
        .mwb_adr_o(mwb_adr_o), .mwb_dat_o(mwb_dat_o),
        .mwb_sel_o(mwb_sel_o), .mwb_wre_o(mwb_wre_o),
        .mwb_stb_o(mwb_stb_o), .mwb_cyc_o(mwb_cyc_o),
        .mwb_dat_i(mwb_dat_i), .mwb_ack_i(mwb_ack_i),
        .xwb_adr_o(xwb_adr_o), .xwb_dat_o(xwb_dat_o),
        .xwb_sel_o(xwb_sel_o), .xwb_wre_o(xwb_wre_o),
        .xwb_stb_o(xwb_stb_o), .xwb_cyc_o(xwb_cyc_o),
        .xwb_dat_i(xwb_dat_i), .xwb_ack_i(xwb_ack_i),
        .xwb_err_i(xwb_err_i)
    );

    // Local RAM: acks one cycle after seeing its strobe.
    always @(posedge clk) begin
        mwb_ack_i <= 1'b0;
        if (mwb_stb_o && mwb_cyc_o) begin
            mwb_ack_i <= 1'b1;
            mwb_dat_i <= ram[mwb_adr_o];
            if (mwb_wre_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mwb_sel_o[b]) begin
                        ram[mwb_adr_o][8*b +: 8] <= mwb_dat_o[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic wre);
        dwb_adr_o = adr;
        dwb_dat_o = dat;
        dwb_sel_o = sel;
        dwb_wre_o = wre;
        dwb_stb_o = 1'b1;
        dwb_cyc_o = 1'b1;
    endtask

    // One cycle after the completion: nothing may restart, then release.
    task automatic tail();
        step();
        chk("tail_cmpl", {dwb_ack_i, dwb_err_i}, 0);
        chk("tail_stb", {mwb_stb_o, xwb_stb_o}, 0);
        dwb_stb_o = 1'b0;
        dwb_cyc_o = 1'b0;
        step();
    endtask

    task automatic do_local(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic wre);
        logic [11:0] w;
        w = adr[13:2];
        drive_req(adr, dat, sel, wre);
        step();
        chk("l_mstb", {mwb_stb_o, mwb_cyc_o}, 2'b11);
        chk("l_madr", mwb_adr_o, w);
        chk("l_msel", mwb_sel_o, sel);
        chk("l_mwre", mwb_wre_o, wre);
        if (wre) chk("l_mdat", mwb_dat_o, dat);
        chk("l_xstb", xwb_stb_o, 0);
        step();
        chk("l_t2", {dwb_ack_i, dwb_err_i, xwb_stb_o}, 0);
        step();
        if (wre) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
            end
        end else begin
            last_rd = ref_mem[w];
        end
        chk("l_t3", {dwb_ack_i, dwb_err_i}, 2'b10);
        chk("l_dat", dwb_dat_i, last_rd);
        chk("l_t3stb", {mwb_stb_o, xwb_stb_o}, 0);
        tail();
    endtask

    // kind: 0 ack, 1 err, 2 err+ack together, 3 no response.
    task automatic do_ext(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic wre,
                          input int d, input int kind,
                          input logic [31:0] rdat);
        int comp;
        comp = (kind == 3) ? TMO + 1 : d + 1;
        drive_req(adr, dat, sel, wre);
        step();
        chk("x_stb", {xwb_stb_o, xwb_cyc_o}, 2'b11);
        chk("x_adr", xwb_adr_o, adr);
        chk("x_sel", xwb_sel_o, sel);
        chk("x_wre", xwb_wre_o, wre);
        chk("x_mstb", mwb_stb_o, 0);
        for (int c = 0; c < comp; c++) begin
            if (c > 0) begin
                chk("x_wait", {dwb_ack_i, dwb_err_i, xwb_stb_o}, 3'b001);
            end
            if (kind != 3 && c == d) begin
                xwb_dat_i = rdat;
                xwb_ack_i = (kind != 1);
                xwb_err_i = (kind != 0);
            end
            step();
        end
        xwb_ack_i = 1'b0;
        xwb_err_i = 1'b0;
        if (kind == 0 && !wre) last_rd = rdat;
        chk("x_cmpl", {dwb_ack_i, dwb_err_i}, (kind == 0) ? 2'b10 : 2'b01);
        chk("x_dat", dwb_dat_i, last_rd);
        chk("x_stbdn", xwb_stb_o, 0);
        tail();
    endtask

    initial begin
        logic [31:0] a, v;
        sys_rst_i = 1'b1;
        drive_req(32'h0, 32'h0, 4'h0, 1'b0);
        dwb_stb_o = 1'b0;
        dwb_cyc_o = 1'b0;
        xwb_dat_i = 32'h0;
        xwb_ack_i = 1'b0;
        xwb_err_i = 1'b0;
        step();
        step();
        chk("rst_flags", {dwb_ack_i, dwb_err_i, mwb_stb_o, mwb_cyc_o,
                          xwb_stb_o, xwb_cyc_o, mwb_wre_o, xwb_wre_o}, 0);
        chk("rst_dat", dwb_dat_i, 0);
        chk("rst_xadr", xwb_adr_o, 0);
        chk("rst_madr", mwb_adr_o, 0);
        sys_rst_i = 1'b0;
        step();

        for (int i = 0; i < 16; i++) do_local(i * 4, $urandom, 4'hF, 1'b1);
        do_local(32'h104, $urandom, 4'hF, 1'b1);
        do_local(32'h3FFC, $urandom, 4'hF, 1'b1);

        do_local(32'h10, 32'h1234_5678, 4'hF, 1'b1);
        do_local(32'h10, 32'h0, 4'hF, 1'b0);
        chk("lrd_val", dwb_dat_i, 32'h1234_5678);

        do_local(32'h104, 32'h0000_AB00, 4'b0010, 1'b1);
        do_local(32'h104, 32'h0, 4'hF, 1'b0);
        chk("byte1", dwb_dat_i[15:8], 8'hAB);

        do_local(32'h3FFC, 32'h0, 4'hF, 1'b0);
        do_ext(32'h4000, 32'h0, 4'hF, 1'b0, 1, 0, 32'h0BAD_F00D);

        do_ext(32'h8000_0000, 32'h0, 4'hF, 1'b0, 5, 0, 32'hCAFE_F00D);
        chk("xrd_val", dwb_dat_i, 32'hCAFE_F00D);
        do_ext(32'h8000_0100, 32'h0, 4'hF, 1'b0, 0, 3, 32'h0);
        do_ext(32'h8000_0200, 32'h0, 4'hF, 1'b0, 2, 2, 32'hDEAD_BEEF);
        chk("errack_dat", dwb_dat_i, 32'hCAFE_F00D);
        do_ext(32'h8000_0300, 32'h0, 4'hF, 1'b0, 3, 1, 32'h1111_1111);
        do_ext(32'h8000_0400, 32'h0, 4'hF, 1'b0, TMO, 0, 32'h5A5A_A5A5);
        do_ext(32'h8000_0500, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0F0F_0F0F);
        do_ext(32'h8000_0600, 32'h77, 4'h1, 1'b1, 4, 0, 32'h2222_2222);

        drive_req(32'h9000_0000, 32'h0, 4'hF, 1'b0);
        step();
        step();
        step();
        sys_rst_i = 1'b1;
        step();
        chk("rst_mid_stb", {xwb_stb_o, mwb_stb_o}, 0);
        chk("rst_mid_cmp", {dwb_ack_i, dwb_err_i}, 0);
        chk("rst_mid_dat", dwb_dat_i, 0);
        sys_rst_i = 1'b0;
        dwb_stb_o = 1'b0;
        dwb_cyc_o = 1'b0;
        last_rd = 32'h0;
        xwb_dat_i = 32'h3333_3333;
        xwb_ack_i = 1'b1;
        step();
        xwb_ack_i = 1'b0;
        chk("late_ack", {dwb_ack_i, dwb_err_i, xwb_stb_o}, 0);
        step();
        chk("late_ack2", {dwb_ack_i, dwb_err_i}, 0);
        do_local(32'h10, 32'h0, 4'hF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 1) begin
                a = $urandom_range(15) * 4;
                if ($urandom_range(1) == 1) begin
                    v = $urandom;
                    do_local(a, v, 4'($urandom_range(15)), 1'b1);
                end else begin
                    do_local(a, 32'h0, 4'hF, 1'b0);
                end
            end else begin
                a = $urandom | 32'h0000_4000;
                do_ext(a, $urandom, 4'hF, 1'($urandom_range(1)),
                       $urandom_range(TMO), $urandom_range(3), $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
